pixel_approx_adder_pipe: RTL and testbench

- Parametrised, 2-stage pipelined lower-part-approximate adder for image-pixel streams. Successor to the fixed 4-bit approximate adders.
- Per beat, the number of approximated LSBs (0 = exact) and output saturation are run-time selectable.
- A mismatch counter tracks how often the approximate result differs from the exact one, for quality characterisation.
- Sits between the pixel source and the filter/blend datapath, with valid/ready on both sides.

---
 rtl/pixel_approx_adder_pipe.sv | 132 +++++++++++++
 tb/tb_pixel_approx_adder_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_approx_adder_pipe.sv
// Two-stage lower-part-OR approximate adder with per-beat approximation depth,
// optional saturation, an exact shadow adder and a saturating mismatch counter.
module pixel_approx_adder_pipe #(
  parameter int W          = 8,
  parameter int MAX_APPROX = 4,
  parameter int CNT_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [W-1:0]                      a,
  input  logic [W-1:0]                      b,
  input  logic [$clog2(MAX_APPROX+1)-1:0]   approx_lsbs,
  input  logic                              sat_en,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [W:0]                        sum,
  output logic                              mismatch,
  input  logic                              cnt_clr,
  output logic [CNT_W-1:0]                  mismatch_cnt
);

  localparam int KW = $clog2(MAX_APPROX + 1);
  localparam int WP = W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage 1 state
  logic          v1_q;
  logic [W-1:0]  a_hi_q, b_hi_q, lo_or_q, ex_lo_q;
  logic          c_q, ex_c_q, sat_q;
  logic [KW-1:0] k_q;

  // Stage 2 state
  logic          v2_q;
  logic [W:0]    sum_q;
  logic          mismatch_q;
  logic [CNT_W-1:0] cnt_q;

  logic s1_adv, s2_adv;

  assign s2_adv   = !v2_q || out_ready;
  assign s1_adv   = !v1_q || s2_adv;
  assign in_ready = s1_adv;

  // Stage 1 combinational: split operands at the clamped boundary k
  logic [KW-1:0] k_d;
  logic [W-1:0]  mask_d, top_d, a_hi_d, b_hi_d, lo_or_d, ex_lo_d;
  logic [W:0]    ex_lo_full_d;
  logic          c_d, ex_c_d;

  always_comb begin
    k_d          = (approx_lsbs > KW'(MAX_APPROX)) ? KW'(MAX_APPROX) : approx_lsbs;
    mask_d       = (W'(1) << k_d) - W'(1);
    top_d        = mask_d & ~(mask_d >> 1);
    a_hi_d       = a >> k_d;
    b_hi_d       = b >> k_d;
    lo_or_d      = (a | b) & mask_d;
    c_d          = |(a & b & top_d);
    ex_lo_full_d = {1'b0, a & mask_d} + {1'b0, b & mask_d};
    ex_c_d       = |(ex_lo_full_d >> k_d);
    ex_lo_d      = ex_lo_full_d[W-1:0] & mask_d;
  end

  function automatic logic [W:0] clamp_sat(input logic [W:0] v, input logic s);
    return (s && v[W]) ? {1'b0, {W{1'b1}}} : v;
  endfunction

  // Stage 2 combinational: approximate and exact upper adds share operands
  logic [W:0] app_up_d, ex_up_d, app_full_d, ex_full_d, sum_d;
  logic       mismatch_d;

  always_comb begin
    app_up_d   = {1'b0, a_hi_q} + {1'b0, b_hi_q} + WP'(c_q);
    ex_up_d    = {1'b0, a_hi_q} + {1'b0, b_hi_q} + WP'(ex_c_q);
    app_full_d = (app_up_d << k_q) | {1'b0, lo_or_q};
    ex_full_d  = (ex_up_d << k_q) | {1'b0, ex_lo_q};
    sum_d      = clamp_sat(app_full_d, sat_q);
    mismatch_d = (sum_d != clamp_sat(ex_full_d, sat_q));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      a_hi_q     <= '0;
      b_hi_q     <= '0;
      lo_or_q    <= '0;
      ex_lo_q    <= '0;
      c_q        <= 1'b0;
      ex_c_q     <= 1'b0;
      sat_q      <= 1'b0;
      k_q        <= '0;
      v2_q       <= 1'b0;
      sum_q      <= '0;
      mismatch_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (s1_adv) begin
        v1_q <= in_valid;
        if (in_valid) begin
          a_hi_q  <= a_hi_d;
          b_hi_q  <= b_hi_d;
          lo_or_q <= lo_or_d;
          ex_lo_q <= ex_lo_d;
          c_q     <= c_d;
          ex_c_q  <= ex_c_d;
          sat_q   <= sat_en;
          k_q     <= k_d;
        end
      end
      if (s2_adv) begin
        v2_q <= v1_q;
        if (v1_q) begin
          sum_q      <= sum_d;
          mismatch_q <= mismatch_d;
        end
      end
      // Clear has priority over a coincident increment
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (v2_q && out_ready && mismatch_q && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid    = v2_q;
  assign sum          = sum_q;
  assign mismatch     = mismatch_q;
  assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_pixel_approx_adder_pipe.sv
// Directed bench: exact/approximate/clamped/saturated beats, backpressure,
// counter saturation and clear priority, and mid-stream reset.
module tb_pixel_approx_adder_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         sat_en = 1'b0;
  logic         cnt_clr = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   approx_lsbs = '0;

  logic         in_ready, out_valid, mismatch;
  logic [W:0]   sum;
  logic [15:0]  mismatch_cnt;
  logic         in_ready2, out_valid2, mismatch2;
  logic [W:0]   sum2;
  logic [1:0]   cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pixel_approx_adder_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx_lsbs(approx_lsbs), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .mismatch(mismatch),
    .cnt_clr(cnt_clr), .mismatch_cnt(mismatch_cnt)
  );

  // Narrow counter instance for saturation behaviour
  pixel_approx_adder_pipe #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .approx_lsbs(approx_lsbs), .sat_en(sat_en),
    .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2), .mismatch(mismatch2),
    .cnt_clr(cnt_clr), .mismatch_cnt(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] kv,
                       input logic sv);
    in_valid    = 1'b1;
    a           = av;
    b           = bv;
    approx_lsbs = kv;
    sat_en      = sv;
    #1;
    check("in_ready", 32'(in_ready), 32'd1);
  endtask

  // Drives one beat and checks it appears exactly two cycles after acceptance
  task automatic one_beat(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [2:0] kv, input logic sv,
                          input logic [8:0] es, input logic em);
    drive(av, bv, kv, sv);
    tick();
    in_valid    = 1'b0;
    a           = 8'($urandom);
    b           = 8'($urandom);
    approx_lsbs = 3'($urandom);
    #1;
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_mm"}, 32'(mismatch), 32'(em));
    $display("beat %s a=%0d b=%0d k=%0d sat=%0d -> sum=%0d mismatch=%0d",
             tag, av, bv, kv, sv, sum, mismatch);
  endtask

  initial begin
    int tx, rx, c;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_mm", 32'(mismatch), 32'd0);
    check("rst_cnt", 32'(mismatch_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Exact mode, back-to-back beats
    drive(8'd9, 8'd10, 3'd0, 1'b0);
    tick();
    drive(8'd11, 8'd12, 3'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    check("exact1_valid", 32'(out_valid), 32'd1);
    check("exact1_sum", 32'(sum), 32'd19);
    check("exact1_mm", 32'(mismatch), 32'd0);
    tick();
    check("exact2_valid", 32'(out_valid), 32'd1);
    check("exact2_sum", 32'(sum), 32'd23);
    check("exact2_mm", 32'(mismatch), 32'd0);
    tick();
    check("exact_drain", 32'(out_valid), 32'd0);
    check("exact_cnt", 32'(mismatch_cnt), 32'd0);

    // Approximate modes and clamping of k
    one_beat("k2", 8'h0B, 8'h0E, 3'd2, 1'b0, 9'd27, 1'b1);
    tick();
    check("k2_cnt", 32'(mismatch_cnt), 32'd1);
    one_beat("k4", 8'd9, 8'd10, 3'd4, 1'b0, 9'd27, 1'b1);
    tick();
    check("k4_cnt", 32'(mismatch_cnt), 32'd2);
    one_beat("k7clamp", 8'd9, 8'd10, 3'd7, 1'b0, 9'd27, 1'b1);
    tick();
    check("k7_cnt", 32'(mismatch_cnt), 32'd3);
    check("k7_cnt2", 32'(cnt2), 32'd3);

    // Saturation, exact and approximate
    one_beat("nosat", 8'd200, 8'd100, 3'd0, 1'b0, 9'd300, 1'b0);
    tick();
    one_beat("sat", 8'd200, 8'd100, 3'd0, 1'b1, 9'd255, 1'b0);
    tick();
    one_beat("sat_k4", 8'd255, 8'd255, 3'd4, 1'b1, 9'd255, 1'b0);
    tick();
    one_beat("nosat_k4", 8'd255, 8'd255, 3'd4, 1'b0, 9'd511, 1'b1);
    tick();
    check("sat_cnt", 32'(mismatch_cnt), 32'd4);
    check("sat_cnt2_stuck", 32'(cnt2), 32'd3);

    // Backpressure: five beats, out_ready low for three cycles after first output
    tx = 0;
    rx = 0;
    c  = 0;
    while (rx < 5 && c < 40) begin
      in_valid    = (tx < 5);
      a           = 8'(10 * (tx + 1));
      b           = 8'(tx + 1);
      approx_lsbs = 3'd0;
      sat_en      = 1'b0;
      out_ready   = !(c >= 2 && c <= 4);
      #1;
      if (c >= 2 && c <= 4) begin
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_valid_hold", 32'(out_valid), 32'd1);
        check("bp_sum_hold", 32'(sum), 32'd11);
      end
      if (out_valid && out_ready) begin
        check("bp_order", 32'(sum), 32'(11 * (rx + 1)));
        $display("bp beat %0d delivered sum=%0d", rx, sum);
        rx++;
      end
      if (in_valid && in_ready) tx++;
      tick();
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_delivered", 32'(rx), 32'd5);
    check("bp_accepted", 32'(tx), 32'd5);
    #1;
    check("bp_no_dup", 32'(out_valid), 32'd0);

    // Counter: clear, then saturate the narrow instance
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnt", 32'(mismatch_cnt), 32'd0);
    check("clr_cnt2", 32'(cnt2), 32'd0);
    for (int i = 0; i < 5; i++) begin
      one_beat("mm_run", 8'h0B, 8'h0E, 3'd2, 1'b0, 9'd27, 1'b1);
      tick();
    end
    check("run_cnt", 32'(mismatch_cnt), 32'd5);
    check("run_cnt2_sat", 32'(cnt2), 32'd3);

    // Clear coincident with a mismatching handshake
    one_beat("clr_same", 8'd9, 8'd10, 3'd4, 1'b0, 9'd27, 1'b1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_win_cnt", 32'(mismatch_cnt), 32'd0);
    check("clr_win_cnt2", 32'(cnt2), 32'd0);
    check("clr_drained", 32'(out_valid), 32'd0);

    // Reset with both stages full
    one_beat("pre_rst", 8'h0B, 8'h0E, 3'd2, 1'b0, 9'd27, 1'b1);
    tick();
    check("pre_rst_cnt", 32'(mismatch_cnt), 32'd1);
    out_ready = 1'b0;
    drive(8'd1, 8'd2, 3'd0, 1'b0);
    tick();
    drive(8'd3, 8'd4, 3'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_mm", 32'(mismatch), 32'd0);
    check("mid_rst_cnt", 32'(mismatch_cnt), 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end
    one_beat("post_rst", 8'd100, 8'd27, 3'd0, 1'b0, 9'd127, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
